// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake, flush/hazard bubbles and WB operand refresh.
// Optional macro IDEX_WB_BYPASS_EN: forward a same-cycle WB write into the captured operands.
module idex_pipe_reg #(
  parameter int                 XLEN      = 64,
  parameter int                 CTRL_W    = 32,
  parameter logic [CTRL_W-1:0]  SIDE_MASK = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_snxt_pc,
  input  logic [31:0]       in_instr,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  input  logic              hz_bubble,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_snxt_pc,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [XLEN-1:0]   out_imm,
  output logic [31:0]       out_instr,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d, snxt_q, snxt_d, imm_q, imm_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [31:0]       instr_q, instr_d;
  logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  logic            advance, capture, hold, wb_live;
  logic            refresh1, refresh2;
  logic [XLEN-1:0] cap_rs1_data, cap_rs2_data;

  always_comb begin
    advance  = !valid_q | out_ready;
    in_ready = advance & !hz_bubble & !flush;
    capture  = in_valid & in_ready;
    hold     = !advance & !flush;
    wb_live  = wb_en & (wb_rd != 5'd0);
    refresh1 = hold & valid_q & wb_live & (wb_rd == rs1_q);
    refresh2 = hold & valid_q & wb_live & (wb_rd == rs2_q);
  end

  always_comb begin
`ifdef IDEX_WB_BYPASS_EN
    cap_rs1_data = (wb_live && wb_rd == in_rs1) ? wb_data : in_rs1_data;
    cap_rs2_data = (wb_live && wb_rd == in_rs2) ? wb_data : in_rs2_data;
`else
    cap_rs1_data = in_rs1_data;
    cap_rs2_data = in_rs2_data;
`endif
  end

  // Valid follows the bubble priority: flush, hazard, capture, drain, else hold.
  always_comb begin
    valid_d = valid_q;
    if (flush)                      valid_d = 1'b0;
    else if (hz_bubble && advance)  valid_d = 1'b0;
    else if (capture)               valid_d = 1'b1;
    else if (advance)               valid_d = 1'b0;
  end

  always_comb begin
    pc_d       = pc_q;
    snxt_d     = snxt_q;
    imm_d      = imm_q;
    instr_d    = instr_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    if (capture) begin
      pc_d       = in_pc;
      snxt_d     = in_snxt_pc;
      imm_d      = in_imm;
      instr_d    = in_instr;
      rs1_d      = in_rs1;
      rs2_d      = in_rs2;
      rd_d       = in_rd;
      ctrl_d     = in_ctrl;
      rs1_data_d = cap_rs1_data;
      rs2_data_d = cap_rs2_data;
    end else begin
      if (refresh1) rs1_data_d = wb_data;
      if (refresh2) rs2_data_d = wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      snxt_q     <= '0;
      imm_q      <= '0;
      instr_q    <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      snxt_q     <= snxt_d;
      imm_q      <= imm_d;
      instr_q    <= instr_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

  // Side-effect control bits must never leak out of a bubble.
  assign out_ctrl     = valid_q ? ctrl_q : (ctrl_q & ~SIDE_MASK);
  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_snxt_pc  = snxt_q;
  assign out_imm      = imm_q;
  assign out_instr    = instr_q;
  assign out_rs1      = rs1_q;
  assign out_rs2      = rs2_q;
  assign out_rd       = rd_q;
  assign out_rs1_data = rs1_data_q;
  assign out_rs2_data = rs2_data_q;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Table-driven scoreboard bench for idex_pipe_reg, run on a 64/32 and a 32/20 instance in lockstep.
module tb_idex_pipe_reg;

  localparam logic [31:0] MASK = 32'hFF;
`ifdef IDEX_WB_BYPASS_EN
  localparam logic [63:0] BYP_D2 = 64'h22;
`else
  localparam logic [63:0] BYP_D2 = 64'h11;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, hz_bubble, wb_en, out_ready;
  logic [63:0] in_pc, in_snxt_pc, in_rs1_data, in_rs2_data, in_imm, wb_data;
  logic [31:0] in_instr, in_ctrl;
  logic [4:0]  in_rs1, in_rs2, in_rd, wb_rd;

  logic        in_ready, out_valid;
  logic [63:0] out_pc, out_snxt_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [31:0] out_instr, out_ctrl;
  logic [4:0]  out_rs1, out_rs2, out_rd;

  logic        r32, v32;
  logic [31:0] pc32, snxt32, d1_32, d2_32, imm32, instr32;
  logic [19:0] ctrl32;
  logic [4:0]  rs1_32, rs2_32, rd32;

  always #5 clk = ~clk;

  idex_pipe_reg #(.XLEN(64), .CTRL_W(32), .SIDE_MASK(32'hFF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_snxt_pc(in_snxt_pc), .in_instr(in_instr),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_ctrl(in_ctrl), .flush(flush), .hz_bubble(hz_bubble),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_snxt_pc(out_snxt_pc), .out_rs1_data(out_rs1_data),
    .out_rs2_data(out_rs2_data), .out_imm(out_imm), .out_instr(out_instr),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_ctrl(out_ctrl)
  );

  idex_pipe_reg #(.XLEN(32), .CTRL_W(20), .SIDE_MASK(20'hFF)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32),
    .in_pc(in_pc[31:0]), .in_snxt_pc(in_snxt_pc[31:0]), .in_instr(in_instr),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data[31:0]), .in_rs2_data(in_rs2_data[31:0]),
    .in_imm(in_imm[31:0]), .in_ctrl(in_ctrl[19:0]), .flush(flush),
    .hz_bubble(hz_bubble), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data[31:0]),
    .out_valid(v32), .out_ready(out_ready),
    .out_pc(pc32), .out_snxt_pc(snxt32), .out_rs1_data(d1_32),
    .out_rs2_data(d2_32), .out_imm(imm32), .out_instr(instr32),
    .out_rs1(rs1_32), .out_rs2(rs2_32), .out_rd(rd32), .out_ctrl(ctrl32)
  );

  typedef struct {
    bit          iv, fl, hz, ordy, wben;
    logic [4:0]  wbrd;
    logic [63:0] wbd, pc;
    logic [31:0] instr;
    logic [4:0]  rs1, rs2;
    logic [63:0] d1, d2;
    logic [31:0] ctrl;
    bit          ir, ov;
    int          src;
    logic [63:0] ed1, ed2;
  } vec_t;

  typedef struct {
    bit          ov;
    logic [63:0] pc, snxt, imm, d1, d2;
    logic [31:0] instr, ctrl;
    logic [4:0]  rs1, rs2, rd;
  } exp_t;

  vec_t tbl[22];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  function automatic vec_t mk(bit iv, bit fl, bit hz, bit ordy, bit wben,
                              logic [4:0] wbrd, logic [63:0] wbd, logic [63:0] pc,
                              logic [31:0] instr, logic [4:0] rs1, logic [4:0] rs2,
                              logic [63:0] d1, logic [63:0] d2, logic [31:0] ctrl,
                              bit ir, bit ov, int src, logic [63:0] ed1, logic [63:0] ed2);
    vec_t v;
    v.iv = iv; v.fl = fl; v.hz = hz; v.ordy = ordy; v.wben = wben;
    v.wbrd = wbrd; v.wbd = wbd; v.pc = pc; v.instr = instr;
    v.rs1 = rs1; v.rs2 = rs2; v.d1 = d1; v.d2 = d2; v.ctrl = ctrl;
    v.ir = ir; v.ov = ov; v.src = src; v.ed1 = ed1; v.ed2 = ed2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid    = v.iv;
    flush       = v.fl;
    hz_bubble   = v.hz;
    out_ready   = v.ordy;
    wb_en       = v.wben;
    wb_rd       = v.wbrd;
    wb_data     = v.wbd;
    in_pc       = v.pc;
    in_snxt_pc  = v.pc + 64'd4;
    in_imm      = v.pc + 64'h100;
    in_instr    = v.instr;
    in_rs1      = v.rs1;
    in_rs2      = v.rs2;
    in_rd       = v.rs1 + 5'd1;
    in_rs1_data = v.d1;
    in_rs2_data = v.d2;
    in_ctrl     = v.ctrl;
  endtask

  task automatic checkOutput(input int k);
    exp_t e;
    if (sb.size() == 0) begin
      chk($sformatf("v%0d scoreboard empty", k), 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("v%0d valid", k), {63'd0, out_valid}, {63'd0, e.ov});
    chk($sformatf("v%0d pc", k), out_pc, e.pc);
    chk($sformatf("v%0d snxt", k), out_snxt_pc, e.snxt);
    chk($sformatf("v%0d imm", k), out_imm, e.imm);
    chk($sformatf("v%0d instr", k), {32'd0, out_instr}, {32'd0, e.instr});
    chk($sformatf("v%0d regs", k), {49'd0, out_rs1, out_rs2, out_rd}, {49'd0, e.rs1, e.rs2, e.rd});
    chk($sformatf("v%0d rs1_data", k), out_rs1_data, e.d1);
    chk($sformatf("v%0d rs2_data", k), out_rs2_data, e.d2);
    chk($sformatf("v%0d ctrl", k), {32'd0, out_ctrl}, {32'd0, e.ctrl});
    chk($sformatf("v%0d w32 valid", k), {63'd0, v32}, {63'd0, e.ov});
    chk($sformatf("v%0d w32 pc", k), {32'd0, pc32}, {32'd0, e.pc[31:0]});
    chk($sformatf("v%0d w32 snxt/imm", k), {snxt32, imm32}, {e.snxt[31:0], e.imm[31:0]});
    chk($sformatf("v%0d w32 instr", k), {32'd0, instr32}, {32'd0, e.instr});
    chk($sformatf("v%0d w32 regs", k), {49'd0, rs1_32, rs2_32, rd32}, {49'd0, e.rs1, e.rs2, e.rd});
    chk($sformatf("v%0d w32 data", k), {d1_32, d2_32}, {e.d1[31:0], e.d2[31:0]});
    chk($sformatf("v%0d w32 ctrl", k), {44'd0, ctrl32}, {44'd0, e.ctrl[19:0]});
  endtask

  task automatic applyStimulus(input int k);
    exp_t e;
    vec_t s;
    @(negedge clk);
    drive(tbl[k]);
    #1;
    chk($sformatf("v%0d in_ready", k), {63'd0, in_ready}, {63'd0, tbl[k].ir});
    chk($sformatf("v%0d w32 in_ready", k), {63'd0, r32}, {63'd0, tbl[k].ir});
    s       = tbl[tbl[k].src];
    e.ov    = tbl[k].ov;
    e.pc    = s.pc;
    e.snxt  = s.pc + 64'd4;
    e.imm   = s.pc + 64'h100;
    e.instr = s.instr;
    e.rs1   = s.rs1;
    e.rs2   = s.rs2;
    e.rd    = s.rs1 + 5'd1;
    e.d1    = tbl[k].ed1;
    e.d2    = tbl[k].ed2;
    e.ctrl  = e.ov ? s.ctrl : (s.ctrl & ~MASK);
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(k);
  endtask

  initial begin
    vec_t z, pre;
    //          iv fl hz ordy wben wbrd wbd       pc               instr         rs1 rs2 d1       d2      ctrl      ir ov src ed1      ed2
    tbl[0]  = mk(1, 0, 0, 1, 0, 0, 0,        64'h8000_0000, 32'h0010_0093, 1, 2, 64'h10, 64'h20, 32'h101, 1, 1, 0,  64'h10,  64'h20);
    tbl[1]  = mk(1, 0, 0, 1, 0, 0, 0,        64'h8000_0004, 32'h0020_0113, 3, 4, 64'h30, 64'h40, 32'h102, 1, 1, 1,  64'h30,  64'h40);
    tbl[2]  = mk(1, 0, 0, 1, 0, 0, 0,        64'h8000_0008, 32'h0030_0193, 5, 6, 64'h50, 64'h60, 32'h003, 1, 1, 2,  64'h50,  64'h60);
    tbl[3]  = mk(1, 0, 0, 1, 0, 0, 0,        64'h8000_000C, 32'h00A0_0093, 1, 0, 64'h00, 64'h07, 32'h0FF, 1, 1, 3,  64'h00,  64'h07);
    tbl[4]  = mk(1, 0, 0, 0, 1, 1, 64'h55,   64'h8000_0010, 32'h0000_0013, 7, 8, 64'h70, 64'h80, 32'h1FF, 0, 1, 3,  64'h55,  64'h07);
    tbl[5]  = mk(1, 0, 0, 0, 1, 0, 64'h99,   64'h8000_0010, 32'h0000_0013, 7, 8, 64'h70, 64'h80, 32'h1FF, 0, 1, 3,  64'h55,  64'h07);
    tbl[6]  = mk(1, 0, 1, 0, 1, 1, 64'h66,   64'h8000_0010, 32'h0000_0013, 7, 8, 64'h70, 64'h80, 32'h1FF, 0, 1, 3,  64'h66,  64'h07);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0,        64'h8000_0010, 32'h0000_0013, 7, 8, 64'h70, 64'h80, 32'h1FF, 0, 1, 3,  64'h66,  64'h07);
    tbl[8]  = mk(1, 0, 0, 1, 1, 9, 64'hAA,   64'h8000_0010, 32'h0000_0013, 7, 8, 64'h70, 64'h80, 32'h1FF, 1, 1, 8,  64'h70,  64'h80);
    tbl[9]  = mk(1, 1, 0, 1, 0, 0, 0,        64'h8000_0014, 32'h0000_0113, 9, 10, 64'h90, 64'hA0, 32'h1FF, 0, 0, 8, 64'h70,  64'h80);
    tbl[10] = mk(1, 0, 0, 1, 0, 0, 0,        64'h8000_0014, 32'h0000_0113, 9, 10, 64'h91, 64'hA1, 32'h0F0, 1, 1, 10, 64'h91, 64'hA1);
    tbl[11] = mk(1, 0, 1, 1, 0, 0, 0,        64'h8000_0018, 32'h0000_0193, 11, 12, 64'hB1, 64'hC1, 32'h1F0, 0, 0, 10, 64'h91, 64'hA1);
    tbl[12] = mk(1, 0, 0, 1, 0, 0, 0,        64'h8000_0018, 32'h0000_0193, 11, 12, 64'hB1, 64'hC1, 32'h1F0, 1, 1, 12, 64'hB1, 64'hC1);
    tbl[13] = mk(0, 0, 0, 1, 0, 0, 0,        64'h0,         32'h0,         0, 0, 64'h0,  64'h0,  32'h0,   1, 0, 12, 64'hB1,  64'hC1);
    tbl[14] = mk(1, 0, 0, 1, 1, 5, 64'h22,   64'h8000_001C, 32'h0000_0213, 6, 5, 64'h33, 64'h11, 32'h004, 1, 1, 14, 64'h33,  BYP_D2);
    tbl[15] = mk(1, 0, 0, 1, 1, 0, 64'h77,   64'h8000_0020, 32'h0000_0293, 0, 0, 64'h44, 64'h45, 32'h008, 1, 1, 15, 64'h44,  64'h45);
    tbl[16] = mk(1, 0, 0, 1, 0, 0, 0,        64'h8000_0024, 32'h0000_0313, 3, 3, 64'h01, 64'h02, 32'h000, 1, 1, 16, 64'h01,  64'h02);
    tbl[17] = mk(0, 0, 0, 0, 1, 3, 64'hBEEF, 64'h0,         32'h0,         0, 0, 64'h0,  64'h0,  32'h0,   0, 1, 16, 64'hBEEF, 64'hBEEF);
    tbl[18] = mk(0, 0, 0, 1, 0, 0, 0,        64'h0,         32'h0,         0, 0, 64'h0,  64'h0,  32'h0,   1, 0, 16, 64'hBEEF, 64'hBEEF);
    tbl[19] = mk(1, 0, 0, 1, 0, 0, 0,        64'h8000_0028, 32'h0000_0393, 4, 4, 64'h05, 64'h06, 32'h0C0, 1, 1, 19, 64'h05,  64'h06);
    tbl[20] = mk(0, 1, 0, 0, 1, 4, 64'hAB,   64'h0,         32'h0,         0, 0, 64'h0,  64'h0,  32'h0,   0, 0, 19, 64'h05,  64'h06);
    tbl[21] = mk(0, 0, 0, 1, 0, 0, 0,        64'h0,         32'h0,         0, 0, 64'h0,  64'h0,  32'h0,   1, 0, 19, 64'h05,  64'h06);

    z   = mk(0, 0, 0, 1, 0, 0, 0, 64'h0, 32'h0, 0, 0, 64'h0, 64'h0, 32'h0, 1, 0, 0, 64'h0, 64'h0);
    pre = mk(1, 0, 0, 1, 0, 0, 0, 64'h8000_0004, 32'h0020_0113, 3, 4, 64'h30, 64'h40, 32'h1FF,
             1, 1, 0, 64'h30, 64'h40);

    rst = 1'b1;
    drive(z);
    repeat (2) @(negedge clk);
    chk("reset valid", {62'd0, out_valid, v32}, 64'd0);
    chk("reset pc", out_pc | {32'd0, pc32}, 64'd0);
    chk("reset ctrl/data", {32'd0, out_ctrl} | out_rs1_data | out_rs2_data, 64'd0);
    chk("reset in_ready", {62'd0, in_ready, r32}, 64'd3);

    rst = 1'b0;
    @(negedge clk);
    drive(pre);
    @(posedge clk);
    #1;
    chk("pre-reset valid", {62'd0, out_valid, v32}, 64'd3);
    chk("pre-reset pc", out_pc, 64'h8000_0004);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset valid", {62'd0, out_valid, v32}, 64'd0);
    chk("async reset pc", out_pc | {32'd0, pc32}, 64'd0);
    chk("async reset ctrl", {32'd0, out_ctrl} | {44'd0, ctrl32}, 64'd0);
    chk("async reset data", out_rs1_data | out_rs2_data | out_imm | out_snxt_pc, 64'd0);
    rst = 1'b0;

    for (int k = 0; k < 22; k++) applyStimulus(k);

    @(negedge clk);
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idex_pipe_reg.md
# idex_pipe_reg

Parametrised ID/EX pipeline register with valid/ready handshake, replacing the fixed-width decode-stage flop bank. Captures the decoded control bundle, operands, immediate, PC and instruction from decode, inserts bubbles on flush or load-use hazard, and holds its contents under back-pressure from EX. While holding, it keeps operands coherent with writeback by refreshing them from the WB port. Sits between `idu` decode logic/regfile and the EXU.

## Interface
Parameters:
- `XLEN`, 64: operand, immediate and PC width.
- `CTRL_W`, 32: width of the opaque decoded control bundle.
- `SIDE_MASK`, `{CTRL_W{1'b0}}`: control bits with side effects (jump, branch, load, store, wb, ebreak). These bits are forced to 0 on the output whenever `out_valid`=0.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: decode holds a valid instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_pc` in XLEN: instruction PC.
- `in_snxt_pc` in XLEN: sequential next PC.
- `in_instr` in 32: raw instruction.
- `in_rs1`, `in_rs2`, `in_rd` in 5 each: register indices.
- `in_rs1_data`, `in_rs2_data` in XLEN: regfile read data.
- `in_imm` in XLEN: immediate.
- `in_ctrl` in CTRL_W: decoded control bundle.
- `flush` in 1: kill the held and the incoming instruction (redirect).
- `hz_bubble` in 1: load-use hazard; insert a bubble and refuse input.
- `wb_en` in 1: writeback write enable.
- `wb_rd` in 5: writeback destination index.
- `wb_data` in XLEN: writeback data.
- `out_valid` out 1: EX-side instruction valid.
- `out_ready` in 1: EX accepts.
- `out_pc`, `out_snxt_pc`, `out_rs1_data`, `out_rs2_data`, `out_imm` out XLEN: registered copies.
- `out_instr` out 32: registered instruction.
- `out_rs1`, `out_rs2`, `out_rd` out 5: registered indices.
- `out_ctrl` out CTRL_W: registered control bundle, masked as described under `SIDE_MASK`.

## Operation
- Accept and capture: `advance = !out_valid | out_ready`. `in_ready = advance & !hz_bubble & !flush`. Capture happens when `in_valid & in_ready`.
- Priority per edge, highest first:
  1. `flush`: `out_valid`←0. Payload is not updated.
  2. `hz_bubble & advance`: `out_valid`←0. The incoming instruction is not consumed; decode retries it.
  3. Capture: `out_valid`←1 and all payload is loaded.
  4. `advance & !in_valid`: `out_valid`←0.
  5. Otherwise (stalled, `out_valid & !out_ready`): hold.
- `hz_bubble` during a stall is ignored. The held instruction stays in place.
- Hold refresh: while holding with `out_valid`=1, if `wb_en` and `wb_rd`!=0:
  - `wb_rd`==`out_rs1` replaces `out_rs1_data` with `wb_data`.
  - `wb_rd`==`out_rs2` replaces `out_rs2_data` with `wb_data`.
  - Both may update in the same edge.
- x0 is never bypassed or refreshed.
- `out_ctrl = valid ? ctrl_q : ctrl_q & ~SIDE_MASK`. Non-side-effect bits stay visible for debug.

## Timing
- Latency: 1 cycle, in→out.
- Throughput: 1 instruction per cycle with `out_ready`=1.
- `in_ready` is combinational from `out_valid`, `out_ready`, `hz_bubble` and `flush`. There is no path from `in_valid` to `in_ready`.
- Reset (async assert): all output registers are 0 and `out_valid`=0.
- Reset deassertion mid-stream: the first capture is possible on the first edge after release.
- Flush and capture in the same cycle: flush wins, and the incoming instruction is dropped.
- WB write to a register in the same cycle as capture: handled by the bypass (see Configuration). It is not handled by the refresh logic, which only acts while holding.

## Configuration
- `IDEX_WB_BYPASS_EN` defined:
  - At capture, if `wb_en` and `wb_rd`!=0 and `wb_rd`==`in_rs1` (or `in_rs2`), the captured operand is `wb_data` instead of the regfile data.
  - This covers regfiles without write-before-read.
- `IDEX_WB_BYPASS_EN` undefined:
  - Operands are captured from `in_rs*_data` unchanged.
  - Hold refresh remains active in both builds.

## Test plan
- Reset: assert `rst` mid-cycle with `out_valid`=1 and `out_pc`=0x8000_0004 → outputs 0 immediately, before the next edge. Then stream 3 instructions at PC 0x8000_0000/04/08 with `out_ready`=1 → each appears 1 cycle later in order, with `in_ready` held at 1.
- Stall: hold `out_ready`=0 for 4 cycles with instruction 0x00A00093 held → output is stable and `in_ready`=0. Meanwhile WB writes x1=0x55 with `out_rs1`=1 → `out_rs1_data` becomes 0x55 on the next edge. A WB write to x0 → no change.
- Flush and `in_valid` in the same cycle, with `SIDE_MASK`=0xFF and `ctrl`=0x1FF → `out_valid`=0, `out_ctrl`=0x100. The next instruction is captured normally.
- `hz_bubble` for 1 cycle with `in_valid`=1 → one bubble, `in_ready`=0. The same instruction is captured on the following edge.
- Bypass: capture with `in_rs2`=5, `in_rs2_data`=0x11, and WB x5=0x22 in the same cycle → `out_rs2_data`=0x22 with `IDEX_WB_BYPASS_EN`, 0x11 without.
- Width: instantiate with `XLEN`=32 and `CTRL_W`=20, then repeat the streaming test → identical behaviour.
